// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite bus bundle between one initiator (master) and one responder (slave).
// Ports (by channel):
//   AW: AWADDR, AWPROT, AWVALID -> ; <- AWREADY
//   W : WDATA, WSTRB, WVALID    -> ; <- WREADY
//   B : <- BRESP, BVALID        ; BREADY ->
//   AR: ARADDR, ARPROT, ARVALID -> ; <- ARREADY
//   R : <- RDATA, RRESP, RVALID ; RREADY ->
// Clock and reset are not part of the bundle; they stay plain module ports.
interface axi4_lite_regbank_if #(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]  AWADDR;
    logic [2:0]             AWPROT;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [8*N_BYTES-1:0]   WDATA;
    logic [N_BYTES-1:0]     WSTRB;
    logic                   WVALID;
    logic                   WREADY;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;
    logic [ADDR_WIDTH-1:0]  ARADDR;
    logic [2:0]             ARPROT;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [8*N_BYTES-1:0]   RDATA;
    logic [1:0]             RRESP;
    logic                   RVALID;
    logic                   RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite responder exposing N_REGS read/write registers of 8*N_BYTES bits.
// Write address and data are accepted independently in any order, byte
// strobes are honoured, and every response is held until the initiator takes it.
// Ports:
//   ACLK       - clock, all logic on the rising edge
//   ARESET     - synchronous reset, active-high
//   bus        - AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   regs_o     - register contents, register k at [k*8*N_BYTES +: 8*N_BYTES]
//   wr_pulse_o - bit k high for the single cycle in which register k updates
// Optional feature macro: AXI4_LITE_REGBANK_SLVERR_EN
//   defined   - out-of-range accesses answer SLVERR (2'b10)
//   undefined - out-of-range accesses answer OKAY (2'b00)
// Out-of-range writes never change a register; out-of-range reads return 0.
module axi4_lite_regbank #(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int N_REGS     = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi4_lite_regbank_if.slave          bus,
    output logic [N_REGS*8*N_BYTES-1:0] regs_o,
    output logic [N_REGS-1:0]           wr_pulse_o
);
    localparam int DW  = 8 * N_BYTES;
    localparam int LSB = $clog2(N_BYTES);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REGBANK_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic          up;
    logic          aw_got, w_got;
    logic [IW-1:0] aw_idx;
    logic [DW-1:0] w_data;
    logic [N_BYTES-1:0] w_strb;
    logic [DW-1:0] regs [N_REGS];
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rd_val;
    logic [IW-1:0] ar_idx;
    logic          aw_ready, w_ready, ar_ready;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic          aw_in_range, ar_in_range;
    logic          unused_bits;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.AWADDR[LSB-1:0], bus.ARADDR[LSB-1:0]};

    assign ar_idx      = bus.ARADDR[ADDR_WIDTH-1:LSB];
    assign aw_in_range = 32'(aw_idx) < 32'(N_REGS);
    assign ar_in_range = 32'(ar_idx) < 32'(N_REGS);

    assign aw_hs = aw_ready && bus.AWVALID;
    assign w_hs  = w_ready  && bus.WVALID;
    assign ar_hs = ar_ready && bus.ARVALID;

    assign bus.AWREADY = aw_ready;
    assign bus.WREADY  = w_ready;
    assign bus.ARREADY = ar_ready;
    assign bus.BRESP   = bresp;
    assign bus.RRESP   = rresp;
    assign bus.RDATA   = rdata;

    // Next-state and handshake outputs; READYs come from registered state only.
    always_comb begin
        w_state_nxt = w_state;
        r_state_nxt = r_state;
        aw_ready    = up && (w_state == W_IDLE) && !aw_got;
        w_ready     = up && (w_state == W_IDLE) && !w_got;
        ar_ready    = up && (r_state == R_IDLE);
        bus.BVALID  = (w_state == W_RESP);
        bus.RVALID  = (r_state == R_RESP);
        commit      = (w_state == W_IDLE) && aw_got && w_got;
        unique case (w_state)
            W_IDLE: if (commit) w_state_nxt = W_RESP;
            W_RESP: if (bus.BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        unique case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_RESP;
            R_RESP: if (bus.RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read mux: an index matching no register yields 0.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (32'(ar_idx) == 32'(k)) rd_val = regs[k];
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < N_REGS; k++) regs_o[k*DW +: DW] = regs[k];
    end

    // Control state: FSMs, hold flags and the post-reset enable.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            up      <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            up      <= 1'b1;
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            if (commit) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
        end
    end

    // Latched AW/W payloads; only meaningful while the matching flag is set.
    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_idx <= bus.AWADDR[ADDR_WIDTH-1:LSB];
        if (w_hs) begin
            w_data <= bus.WDATA;
            w_strb <= bus.WSTRB;
        end
    end

    // Register bank, write pulses and response payloads.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
            wr_pulse_o <= '0;
            bresp      <= RESP_OKAY;
            rresp      <= RESP_OKAY;
            rdata      <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit) begin
                for (int k = 0; k < N_REGS; k++) begin
                    if (32'(aw_idx) == 32'(k)) begin
                        wr_pulse_o[k] <= 1'b1;
                        for (int i = 0; i < N_BYTES; i++) begin
                            if (w_strb[i]) regs[k][8*i +: 8] <= w_data[8*i +: 8];
                        end
                    end
                end
                bresp <= aw_in_range ? RESP_OKAY : RESP_OOR;
            end
            // Nonblocking read of regs returns the value before a same-edge write.
            if (ar_hs) begin
                rdata <= rd_val;
                rresp <= ar_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end
endmodule
